// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, line/frame total helper and RGB332 field positions.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // RGB332 byte layout: {R[2:0], G[2:0], B[1:0]}
   localparam int R_HI = 7;
   localparam int R_LO = 5;
   localparam int G_HI = 4;
   localparam int G_LO = 2;
   localparam int B_HI = 1;
   localparam int B_LO = 0;

   function automatic int line_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO; a flush discards contents but keeps a same-cycle push.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Flush drops everything up to the write pointer, so a simultaneous push survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= (AW+1)'(1);
         end else begin
            count  <= '0;
         end
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: byte FIFO intake, 640x480@60 timing at clk/2, frame_sync at start of vblank.
// Optional underflow counter port enabled by VGA_SCANOUT_UNDERFLOW_CNT_EN.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_i,
   input  logic       stb_i,
   output logic       ack_i,
   output logic       frame_sync,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [1:0] blue,
   output logic       de
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
   ,
   output logic [15:0] underflow_cnt
`endif
);

   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);

   logic           pix_ce;
   logic [H_W-1:0] h;
   logic [V_W-1:0] v;
   logic           active;
   logic           hs_zone;
   logic           vs_zone;
   logic           sync_pt;
   logic           push;
   logic           pop;
   logic           flush;
   logic           full;
   logic           empty;
   logic [7:0]     dout;
   logic [7:0]     pix;

   always_comb begin
      active  = (h < H_W'(H_ACTIVE)) && (v < V_W'(V_ACTIVE));
      hs_zone = (h >= H_W'(H_ACTIVE + H_FP)) && (h < H_W'(H_ACTIVE + H_FP + H_SYNC));
      vs_zone = (v >= V_W'(V_ACTIVE + V_FP)) && (v < V_W'(V_ACTIVE + V_FP + V_SYNC));
      sync_pt = (h == '0) && (v == V_W'(V_ACTIVE));
      // ack_i high last cycle blocks re-accepting the same held strobe
      push    = stb_i && !ack_i && !full;
      pop     = pix_ce && active && !empty;
      flush   = pix_ce && sync_pt;
      pix     = pop ? dout : 8'h00;
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (data_i),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   // Reset parks the raster at the top of vertical blanking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_ce <= 1'b0;
         h      <= '0;
         v      <= V_W'(V_ACTIVE);
      end else begin
         pix_ce <= ~pix_ce;
         if (pix_ce) begin
            if (h == H_W'(H_TOTAL - 1)) begin
               h <= '0;
               v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_i      <= 1'b0;
         frame_sync <= 1'b0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         de         <= 1'b0;
         red        <= '0;
         green      <= '0;
         blue       <= '0;
      end else begin
         ack_i      <= push;
         frame_sync <= flush;
         if (pix_ce) begin
            hsync <= !hs_zone;
            vsync <= !vs_zone;
            de    <= active;
            red   <= pix[R_HI:R_LO];
            green <= pix[G_HI:G_LO];
            blue  <= pix[B_HI:B_LO];
         end
      end
   end

`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underflow_cnt <= '0;
      end else if (pix_ce && active && empty && (underflow_cnt != 16'hFFFF)) begin
         underflow_cnt <= underflow_cnt + 1'b1;
      end
   end
`endif

endmodule
